// File: rtl/vram_arbiter_if.sv
// Bundle of the scanout-fetch, CPU and VRAM-macro signals around vram_arbiter.
// The slave modport is the arbiter's view and the master modport is the surrounding logic's view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              vga_overrun;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_data, vga_valid, vga_overrun, cpu_rdata, cpu_ack,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_data, vga_valid, vga_overrun, cpu_rdata, cpu_ack,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between the scanout fetcher (always first) and the CPU.
// Latency: a fetch is delivered 3 cycles after vga_req, and a CPU access is acked 3 cycles after it is granted.
// Backpressure: the VGA side has none (the newest fetch wins and overrun is flagged); the CPU is held off by req/ack.
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    vram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_V = 3'd1,
        CAPT_V  = 3'd2,
        ISSUE_C = 3'd3,
        CAPT_C  = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    state_t            state;
    state_t            state_nx;
    mem_cmd_t          cmd_q;
    mem_cmd_t          cmd_nx;
    logic              pend_v;
    logic              pend_v_nx;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] pend_addr_nx;
    logic              vga_pending;
    logic              cpu_eligible;
    logic              overrun_set;
    logic              overrun_q;
    logic              vga_valid_q;
    logic [DATA_W-1:0] vga_data_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cmd_nx       = cmd_q;
        cmd_nx.we    = 1'b0;
        vga_pending  = pend_v | bus.vga_req;
        cpu_eligible = bus.cpu_req & ~cpu_ack_q & (state != ISSUE_C) & (state != CAPT_C);

        // IDLE, CAPT_V, CAPT_C and any stray encoding all make a fresh decision
        case (state)
            ISSUE_V: state_nx = CAPT_V;
            ISSUE_C: state_nx = CAPT_C;
            default: begin
                if (vga_pending) begin
                    state_nx    = ISSUE_V;
                    cmd_nx.addr = bus.vga_req ? bus.vga_addr : pend_addr;
                end else if (cpu_eligible) begin
                    state_nx     = ISSUE_C;
                    cmd_nx.addr  = bus.cpu_addr;
                    cmd_nx.we    = bus.cpu_we;
                    cmd_nx.wdata = bus.cpu_wdata;
                end else begin
                    state_nx = IDLE;
                end
            end
        endcase

        // A fresh request replaces any older pending address; only an unissued older one counts as overrun
        pend_v_nx    = (state_nx == ISSUE_V) ? 1'b0 : vga_pending;
        pend_addr_nx = bus.vga_req ? bus.vga_addr : pend_addr;
        overrun_set  = bus.vga_req & pend_v;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            pend_v      <= 1'b0;
            pend_addr   <= '0;
            overrun_q   <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            cmd_q       <= cmd_nx;
            pend_v      <= pend_v_nx;
            pend_addr   <= pend_addr_nx;
            overrun_q   <= overrun_q | overrun_set;
            vga_valid_q <= (state == CAPT_V);
            cpu_ack_q   <= (state == CAPT_C);
            if (state == CAPT_V) begin
                vga_data_q <= bus.mem_rdata;
            end
            if (state == CAPT_C && !bus.cpu_we) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr    = cmd_q.addr;
    assign bus.mem_we      = cmd_q.we;
    assign bus.mem_wdata   = cmd_q.wdata;
    assign bus.vga_valid   = vga_valid_q;
    assign bus.vga_data    = vga_data_q;
    assign bus.vga_overrun = overrun_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_rdata   = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter, with a cycle-scheduled reference of the arbitration rules and a VRAM macro model.
module tb_vram_arbiter;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_arbiter_if b ();
    vram_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(b));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    function automatic logic [15:0] pat(input logic [15:0] a);
        case (a)
            16'h0010: pat = 16'hABCD;
            16'h0001: pat = 16'h1111;
            16'h0002: pat = 16'h2222;
            16'h0006: pat = 16'h6666;
            default:  pat = a ^ 16'hA5C3;
        endcase
    endfunction

    // VRAM macro: 1-cycle synchronous read
    logic [15:0] vram [0:65535];
    bit          vram_ok [0:65535];
    always @(posedge clk) begin
        if (b.mem_we) begin
            vram[b.mem_addr]    <= b.mem_wdata;
            vram_ok[b.mem_addr] <= 1'b1;
        end
        b.mem_rdata <= vram_ok[b.mem_addr] ? vram[b.mem_addr] : pat(b.mem_addr);
    end

    logic [15:0] ref_mem [0:65535];
    bit          ref_ok [0:65535];
    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        ref_rd = ref_ok[a] ? ref_mem[a] : pat(a);
    endfunction

    bit          exp_vv [DEPTH];
    bit          exp_ca [DEPTH];
    bit          exp_cr [DEPTH];
    bit          exp_we [DEPTH];
    bit          exp_mav [DEPTH];
    bit          exp_ov [DEPTH];
    bit          pw_v [DEPTH];
    logic [15:0] exp_vd [DEPTH];
    logic [15:0] exp_cd [DEPTH];
    logic [15:0] exp_ma [DEPTH];
    logic [15:0] exp_wd [DEPTH];
    logic [15:0] pw_a [DEPTH];
    logic [15:0] pw_d [DEPTH];

    bit          pend = 1'b0;
    bit          ovr = 1'b0;
    logic [15:0] pend_addr = 16'h0;
    int          next_dec = 0;
    int          cpu_ok = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: the memory is a slot resource; a decision at cycle k books cycles k+1..k+2
    always @(posedge clk) begin : model
        int k;
        logic [15:0] a;
        k = cyc;
        if (k > DEPTH - 8) begin
            $display("FAIL watchdog: cycle budget exhausted at %0d", k);
            $fatal(1);
        end
        if (pw_v[k]) begin
            ref_mem[pw_a[k]] = pw_d[k];
            ref_ok[pw_a[k]]  = 1'b1;
        end
        if (!rst_n) begin
            for (int j = k + 1; j < DEPTH; j++) begin
                exp_vv[j] = 1'b0; exp_ca[j] = 1'b0; exp_cr[j] = 1'b0;
                exp_we[j] = 1'b0; exp_mav[j] = 1'b0; pw_v[j] = 1'b0;
            end
            pend = 1'b0; ovr = 1'b0; next_dec = k + 1; cpu_ok = k + 1; chk_en = 1'b1;
        end else begin
            if (b.vga_req && pend) ovr = 1'b1;
            if (k >= next_dec && (b.vga_req || pend)) begin
                a = b.vga_req ? b.vga_addr : pend_addr;
                exp_mav[k+1] = 1'b1; exp_ma[k+1] = a;
                exp_vv[k+3]  = 1'b1; exp_vd[k+3] = ref_rd(a);
                next_dec = k + 2;
                pend = 1'b0;
            end else begin
                if (k >= next_dec && k >= cpu_ok && b.cpu_req) begin
                    exp_mav[k+1] = 1'b1; exp_ma[k+1] = b.cpu_addr;
                    exp_we[k+1]  = b.cpu_we; exp_wd[k+1] = b.cpu_wdata;
                    pw_v[k+1] = b.cpu_we; pw_a[k+1] = b.cpu_addr; pw_d[k+1] = b.cpu_wdata;
                    exp_ca[k+3] = 1'b1; exp_cr[k+3] = !b.cpu_we; exp_cd[k+3] = ref_rd(b.cpu_addr);
                    next_dec = k + 2;
                    cpu_ok = k + 4;
                end
                if (b.vga_req) begin
                    pend = 1'b1;
                    pend_addr = b.vga_addr;
                end
            end
        end
        exp_ov[k+1] = ovr;
        cyc = k + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vga_valid", b.vga_valid, exp_vv[cyc]);
            if (exp_vv[cyc]) chk("vga_data", b.vga_data, exp_vd[cyc]);
            chk("cpu_ack", b.cpu_ack, exp_ca[cyc]);
            if (exp_ca[cyc] && exp_cr[cyc]) chk("cpu_rdata", b.cpu_rdata, exp_cd[cyc]);
            chk("mem_we", b.mem_we, exp_we[cyc]);
            if (exp_mav[cyc]) chk("mem_addr", b.mem_addr, exp_ma[cyc]);
            if (exp_we[cyc]) chk("mem_wdata", b.mem_wdata, exp_wd[cyc]);
            chk("vga_overrun", b.vga_overrun, exp_ov[cyc]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  vcnt;
    int  acnt;
    int  adj;
    bit  prev_ack;

    initial begin
        b.vga_req = 1'b0; b.vga_addr = '0;
        b.cpu_req = 1'b0; b.cpu_we = 1'b0; b.cpu_addr = '0; b.cpu_wdata = '0;
        rst_n = 1'b0;

        // reset held 3 cycles under random inputs
        for (int i = 0; i < 3; i++) begin
            b.vga_req   = 1'($urandom_range(0, 1));
            b.vga_addr  = 16'($urandom);
            b.cpu_req   = 1'($urandom_range(0, 1));
            b.cpu_we    = 1'($urandom_range(0, 1));
            b.cpu_addr  = 16'($urandom);
            b.cpu_wdata = 16'($urandom);
            step();
            chk("rst_vga_valid", b.vga_valid, 0);
            chk("rst_cpu_ack", b.cpu_ack, 0);
            chk("rst_mem_we", b.mem_we, 0);
            chk("rst_overrun", b.vga_overrun, 0);
            chk("rst_mem_addr", b.mem_addr, 0);
        end
        rst_n = 1'b1;
        b.vga_req = 1'b0; b.cpu_req = 1'b0; b.cpu_we = 1'b0;
        step(); step();

        // VGA read of 0x0010
        b.vga_req = 1'b1; b.vga_addr = 16'h0010;
        step(); b.vga_req = 1'b0;
        chk("vga_issue_addr", b.mem_addr, 16'h0010);
        chk("vga_issue_we", b.mem_we, 0);
        step(); chk("vga_valid_n2", b.vga_valid, 0);
        step(); chk("vga_valid_n3", b.vga_valid, 1); chk("vga_data_n3", b.vga_data, 16'hABCD);
        step(); chk("vga_valid_n4", b.vga_valid, 0);
        step();

        // CPU write 0x1234 -> 0x0200, then read it back
        b.cpu_req = 1'b1; b.cpu_we = 1'b1; b.cpu_addr = 16'h0200; b.cpu_wdata = 16'h1234;
        step(); chk("wr_we_m1", b.mem_we, 1); chk("wr_addr_m1", b.mem_addr, 16'h0200);
        step(); chk("wr_we_m2", b.mem_we, 0); chk("wr_ack_m2", b.cpu_ack, 0);
        step(); chk("wr_ack_m3", b.cpu_ack, 1); b.cpu_req = 1'b0;
        step(); chk("wr_ack_m4", b.cpu_ack, 0);
        b.cpu_req = 1'b1; b.cpu_we = 1'b0;
        step(); step();
        step(); chk("rd_ack", b.cpu_ack, 1); chk("rd_data", b.cpu_rdata, 16'h1234); b.cpu_req = 1'b0;
        step(); step();

        // collision: VGA 0x0001 and CPU read 0x0002 in the same idle cycle
        b.vga_req = 1'b1; b.vga_addr = 16'h0001;
        b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_addr = 16'h0002;
        step(); b.vga_req = 1'b0;
        step();
        step(); chk("col_vvalid", b.vga_valid, 1); chk("col_vdata", b.vga_data, 16'h1111);
        chk("col_ack_early", b.cpu_ack, 0);
        step();
        step(); chk("col_ack", b.cpu_ack, 1); chk("col_rdata", b.cpu_rdata, 16'h2222); b.cpu_req = 1'b0;
        step(); step(); step();

        // sustained: VGA pulse every 4 cycles, CPU reads continuously
        b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_addr = 16'h0300;
        vcnt = 0; acnt = 0; adj = 0; prev_ack = 1'b0;
        for (int i = 0; i < 80; i++) begin
            b.vga_req = 1'b1; b.vga_addr = 16'h0100 + 16'(i);
            for (int s = 0; s < 4; s++) begin
                step(); b.vga_req = 1'b0;
                if (b.vga_valid) vcnt++;
                if (b.cpu_ack) begin
                    acnt++;
                    if (prev_ack) adj++;
                    b.cpu_addr = b.cpu_addr + 16'h1;
                end
                prev_ack = b.cpu_ack;
            end
        end
        for (int s = 0; s < 8; s++) begin
            step();
            if (b.vga_valid) vcnt++;
            if (b.cpu_ack) begin
                acnt++;
                if (prev_ack) adj++;
                b.cpu_req = 1'b0;
            end
            prev_ack = b.cpu_ack;
        end
        chk("sus_vga_count", vcnt, 80);
        chk("sus_ack_count", acnt, 80);
        chk("sus_double_ack", adj, 0);
        chk("sus_overrun", b.vga_overrun, 0);

        // overrun: two fetches queued while the CPU owns the memory
        b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_addr = 16'h0003;
        step(); b.vga_req = 1'b1; b.vga_addr = 16'h0005;
        step(); b.vga_addr = 16'h0006;
        step(); b.vga_req = 1'b0;
        chk("ovr_cpu_ack", b.cpu_ack, 1); b.cpu_req = 1'b0;
        chk("ovr_flag", b.vga_overrun, 1);
        vcnt = 0;
        for (int s = 0; s < 6; s++) begin
            if (b.vga_valid) begin
                vcnt++;
                chk("ovr_vdata", b.vga_data, 16'h6666);
            end
            step();
        end
        chk("ovr_vga_count", vcnt, 1);
        chk("ovr_sticky", b.vga_overrun, 1);

        // reset during ISSUE_V aborts the fetch and clears overrun
        b.vga_req = 1'b1; b.vga_addr = 16'h0007;
        step(); b.vga_req = 1'b0; rst_n = 1'b0;
        chk("rv_issue_addr", b.mem_addr, 16'h0007);
        step(); rst_n = 1'b1;
        chk("rv_overrun", b.vga_overrun, 0);
        chk("rv_mem_addr", b.mem_addr, 0);
        vcnt = 0;
        for (int s = 0; s < 5; s++) begin
            if (b.vga_valid) vcnt++;
            step();
        end
        chk("rv_no_valid", vcnt, 0);
        chk("rv_overrun_end", b.vga_overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-requester arbiter for the single-port 16-bit VRAM shared by the VGA scanout fetcher and the CPU bus. The scanout side issues one word fetch per 4 pixels (4 packed 4-bit pixels per word, 320-pixel lines) and always has priority. The CPU gets every free memory slot through a req/ack handshake. The block sits between the fetcher/CPU and the VRAM macro, which has a 1-cycle synchronous read.

## Interface
- ADDR_W, 16, VRAM word address width
- DATA_W, 16, VRAM word width

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- vga_req  in  1  single-cycle fetch pulse from the scanout fetcher
- vga_addr  in  ADDR_W  fetch address; sampled only when vga_req=1
- vga_data  out  DATA_W  fetched word; valid only while vga_valid=1
- vga_valid  out  1  one-cycle pulse per completed fetch
- vga_overrun  out  1  sticky flag: a pending fetch was overwritten before it was issued
- cpu_req  in  1  CPU request level; cpu_we, cpu_addr and cpu_wdata stay stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1, undefined on write acks
- cpu_ack  out  1  one-cycle completion pulse for reads and writes
- mem_addr  out  ADDR_W  VRAM address (registered)
- mem_we  out  1  VRAM write enable (registered)
- mem_wdata  out  DATA_W  VRAM write data (registered)
- mem_rdata  in  DATA_W  VRAM read data; valid the cycle after the address is presented

## Operation
- FSM states: IDLE, ISSUE_V, CAPT_V, ISSUE_C, CAPT_C. ISSUE_x drives mem_*. CAPT_x registers mem_rdata.
- Pending VGA fetch = pend_v flag, or a vga_req arriving in the current cycle.
- On vga_req: latch vga_addr into pend_addr and set pend_v. If pend_v is already set and not being issued this cycle, set vga_overrun. The newer address replaces the older one and the older fetch is dropped.
- CPU eligibility: cpu_req=1, cpu_ack=0, and state not in {ISSUE_C, CAPT_C}.
- Decisions are made only in IDLE, CAPT_V and CAPT_C. ISSUE_x always goes to CAPT_x.
  - A pending VGA fetch → ISSUE_V; pend_v clears on entry.
  - Otherwise an eligible CPU → ISSUE_C.
  - Otherwise → IDLE.
- ISSUE_V: mem_addr=pend_addr, mem_we=0.
- ISSUE_C: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
- mem_we is 1 only in ISSUE_C with cpu_we=1, and is 0 in every other state.
- End of CAPT_V: vga_data←mem_rdata; vga_valid=1 for the next cycle.
- End of CAPT_C: cpu_rdata←mem_rdata (reads only); cpu_ack=1 for the next cycle.
- vga_overrun clears only on reset.

## Timing
- Reset (rst_n=0 sampled at an edge): state=IDLE; pend_v=0; vga_overrun=0; all outputs 0.
- Reset mid-operation aborts the access. No vga_valid or cpu_ack is issued for it. A write presented in ISSUE_C before the reset edge may commit.
- VGA latency with the arbiter idle: vga_req at cycle N → ISSUE_V at N+1 → CAPT_V at N+2 → vga_valid at N+3.
- CPU latency with the arbiter idle: cpu_req first high at M → ISSUE_C at M+1 → cpu_ack at M+3. Writes and reads have the same latency.
- After cpu_ack, the CPU either drops cpu_req or presents a new request. The cycle in which cpu_ack=1 never grants the CPU.
- Simultaneous vga_req and eligible cpu_req: VGA is served first and the CPU is issued straight from CAPT_V. vga_valid at N+3, cpu_ack at N+5.
- Throughput: one access per 2 cycles, back-to-back. A VGA pulse every 4 cycles still leaves the CPU one access per 4 cycles, with no overrun.
- A vga_req during ISSUE_V or CAPT_V is legal, because pend_v was already cleared, and is not an overrun.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → vga_valid, cpu_ack, mem_we, vga_overrun, mem_addr all 0; state IDLE.
- VGA read: preload VRAM[0x0010]=0xABCD; vga_req with addr 0x0010 at N → mem_addr=0x0010 and mem_we=0 at N+1; vga_valid=1 with vga_data=0xABCD at N+3 only.
- CPU write then read: write 0x1234 to 0x0200 → mem_we=1 for exactly one cycle (M+1), cpu_ack at M+3. Then read 0x0200 → cpu_ack with cpu_rdata=0x1234.
- Collision: vga_req (addr 0x0001, data 0x1111) and CPU read (addr 0x0002, data 0x2222) in the same IDLE cycle N → vga_valid/0x1111 at N+3, cpu_ack/0x2222 at N+5.
- Sustained load: vga_req every 4 cycles for 80 fetches with cpu_req held high for reads → 80 vga_valid with correct data, vga_overrun=0, a CPU ack every 4 cycles, no double ack.
- Overrun and reset: grant a CPU read, then pulse vga_req (0x0005) in ISSUE_C and vga_req (0x0006) in CAPT_C.
  - Required: vga_overrun=1, and exactly one vga_valid, carrying VRAM[0x0006].
  - Then assert rst_n=0 during a later ISSUE_V. Required: no vga_valid and vga_overrun=0.
